// File: rtl/compuertas_pkg.sv
// compuertas_pkg: shared op codes, FSM state type and widths for the
// compuertas_sweep gate block.
package compuertas_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND3 = 3'd0;
  localparam logic [OP_W-1:0] OP_OR3  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR3 = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND3 = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR3 = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR3 = 3'd5;
  localparam logic [OP_W-1:0] OP_MAJ  = 3'd6;
  localparam logic [OP_W-1:0] OP_MUX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/gate_eval.sv
// gate_eval: combinational bit-wise three-input function evaluator.
module gate_eval
  import compuertas_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] y_o
);

  // Select one of the eight lane-wise functions
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND3:  y_o = a_i & b_i & c_i;
      OP_OR3:   y_o = a_i | b_i | c_i;
      OP_XOR3:  y_o = a_i ^ b_i ^ c_i;
      OP_NAND3: y_o = ~(a_i & b_i & c_i);
      OP_NOR3:  y_o = ~(a_i | b_i | c_i);
      OP_XNOR3: y_o = ~(a_i ^ b_i ^ c_i);
      OP_MAJ:   y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
      OP_MUX:   y_o = (c_i & b_i) | (~c_i & a_i);
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/compuertas_sweep.sv
// compuertas_sweep: registered dual three-input gate block with an optional
// truth-table sweep engine (enabled by defining COMPUERTAS_SWEEP_EN).
module compuertas_sweep
  import compuertas_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [OP_W-1:0]  op1,
  input  logic [OP_W-1:0]  op2,
  input  logic             in_valid,
  input  logic             sweep_start,
  output logic [WIDTH-1:0] S1,
  output logic [WIDTH-1:0] S2,
  output logic             out_valid,
  output logic [2:0]       sweep_idx,
  output logic             sweep_busy,
  output logic             sweep_done
);

  logic [WIDTH-1:0] a_m, b_m, c_m;
  logic [OP_W-1:0]  op1_m, op2_m;
  logic [WIDTH-1:0] s1_d, s2_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic             out_valid_q;

  gate_eval #(.WIDTH(WIDTH)) u_eval1 (
    .op_i (op1_m),
    .a_i  (a_m),
    .b_i  (b_m),
    .c_i  (c_m),
    .y_o  (s1_d)
  );

  gate_eval #(.WIDTH(WIDTH)) u_eval2 (
    .op_i (op2_m),
    .a_i  (a_m),
    .b_i  (b_m),
    .c_i  (c_m),
    .y_o  (s2_d)
  );

`ifdef COMPUERTAS_SWEEP_EN

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [OP_W-1:0] op1_q, op2_q;
  logic [2:0]      sweep_idx_q;
  logic            sweep_busy_q;
  logic            sweep_done_q;

  // Operand mux: sweep counter bits replicated across lanes while sweeping
  always_comb begin
    a_m   = A;
    b_m   = B;
    c_m   = C;
    op1_m = op1;
    op2_m = op2;
    if (state_q == ST_SWEEP) begin
      a_m   = {WIDTH{cnt_q[2]}};
      b_m   = {WIDTH{cnt_q[1]}};
      c_m   = {WIDTH{cnt_q[0]}};
      op1_m = op1_q;
      op2_m = op2_q;
    end
  end

  // Sweep FSM with registered results and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_valid_q  <= 1'b0;
      sweep_idx_q  <= '0;
      sweep_busy_q <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q  <= in_valid;
          sweep_idx_q  <= '0;
          sweep_done_q <= 1'b0;
          if (in_valid) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
          end
          if (sweep_start) begin
            state_q      <= ST_SWEEP;
            cnt_q        <= '0;
            op1_q        <= op1;
            op2_q        <= op2;
            sweep_busy_q <= 1'b1;
          end
        end
        ST_SWEEP: begin
          s1_q        <= s1_d;
          s2_q        <= s2_d;
          out_valid_q <= 1'b1;
          sweep_idx_q <= cnt_q;
          cnt_q       <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q      <= ST_DRAIN;
            sweep_done_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_IDLE;
          out_valid_q  <= 1'b0;
          sweep_idx_q  <= '0;
          sweep_done_q <= 1'b0;
          sweep_busy_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          out_valid_q  <= 1'b0;
          sweep_idx_q  <= '0;
          sweep_done_q <= 1'b0;
          sweep_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_idx  = sweep_idx_q;
  assign sweep_busy = sweep_busy_q;
  assign sweep_done = sweep_done_q;

`else

  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;

  // Direct operands only; no sweep engine in this build
  always_comb begin
    a_m   = A;
    b_m   = B;
    c_m   = C;
    op1_m = op1;
    op2_m = op2;
  end

  // Result registers: capture on every operand strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end
  end

  assign sweep_idx  = '0;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;

`endif

  assign S1        = s1_q;
  assign S2        = s2_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_compuertas_sweep.sv
// tb_compuertas_sweep: table-driven and randomized bench for compuertas_sweep.
module tb_compuertas_sweep;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B, C;
  logic [2:0]   op1, op2;
  logic         in_valid, sweep_start;
  logic [W-1:0] S1, S2;
  logic         out_valid;
  logic [2:0]   sweep_idx;
  logic         sweep_busy, sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

  compuertas_sweep #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .C           (C),
    .op1         (op1),
    .op2         (op2),
    .in_valid    (in_valid),
    .sweep_start (sweep_start),
    .S1          (S1),
    .S2          (S2),
    .out_valid   (out_valid),
    .sweep_idx   (sweep_idx),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a, b, c;
    logic [2:0]   o1, o2;
    logic [W-1:0] e1, e2;
  } vec_t;

  vec_t tbl[5];

  // Reference: count the ones in each lane and apply the function's rule
  function automatic logic [W-1:0] model(input logic [2:0] op,
                                         input logic [W-1:0] a, b, c);
    logic [W-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < W; i++) begin
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      case (op)
        3'd0: r[i] = (ones == 3);
        3'd1: r[i] = (ones > 0);
        3'd2: r[i] = (ones % 2 == 1);
        3'd3: r[i] = (ones != 3);
        3'd4: r[i] = (ones == 0);
        3'd5: r[i] = (ones % 2 == 0);
        3'd6: r[i] = (ones >= 2);
        default: r[i] = c[i] ? b[i] : a[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(sweep_busy), 32'd0);
    chk({tag, "_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_idx"}, 32'(sweep_idx), 32'd0);
  endtask

  task automatic junk_inputs();
    A           = W'($urandom);
    B           = W'($urandom);
    C           = W'($urandom);
    op1         = 3'($urandom);
    op2         = 3'($urandom);
    in_valid    = 1'($urandom);
    sweep_start = 1'($urandom);
  endtask

  // Eight sweep results with latched ops, inputs scrambled meanwhile, then drain
  task automatic run_sweep(input logic [2:0] o1, input logic [2:0] o2);
    logic [W-1:0] ra, rb, rc;
    for (int k = 0; k < 8; k++) begin
      tick();
      ra = {W{k[2]}};
      rb = {W{k[1]}};
      rc = {W{k[0]}};
      chk("sweep_valid", 32'(out_valid), 32'd1);
      chk("sweep_idx", 32'(sweep_idx), 32'(k));
      chk("sweep_S1", 32'(S1), 32'(model(o1, ra, rb, rc)));
      chk("sweep_S2", 32'(S2), 32'(model(o2, ra, rb, rc)));
      chk("sweep_done", 32'(sweep_done), (k == 7) ? 32'd1 : 32'd0);
      chk("sweep_busy", 32'(sweep_busy), 32'd1);
      junk_inputs();
    end
    tick();
    chk_idle_outputs("drain");
    in_valid    = 1'b0;
    sweep_start = 1'b0;
  endtask

  initial begin : main
    logic [W-1:0] exp1, exp2;

    tbl[0] = '{a: 4'b1100, b: 4'b1010, c: 4'b1111, o1: 3'd0, o2: 3'd2, e1: 4'b1000, e2: 4'b1001};
    tbl[1] = '{a: 4'b0011, b: 4'b0101, c: 4'b1111, o1: 3'd6, o2: 3'd7, e1: 4'b0111, e2: 4'b0101};
    tbl[2] = '{a: 4'b1010, b: 4'b0110, c: 4'b0011, o1: 3'd3, o2: 3'd4, e1: 4'b1101, e2: 4'b0000};
    tbl[3] = '{a: 4'b1010, b: 4'b0110, c: 4'b0011, o1: 3'd5, o2: 3'd1, e1: 4'b0000, e2: 4'b1111};
    tbl[4] = '{a: 4'b1010, b: 4'b0110, c: 4'b0011, o1: 3'd7, o2: 3'd6, e1: 4'b1010, e2: 4'b0010};

    // Reset with random inputs
    rst = 1'b1;
    junk_inputs();
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_S1", 32'(S1), 32'd0);
      chk("rst_S2", 32'(S2), 32'd0);
      chk_idle_outputs("rst");
      junk_inputs();
    end
    rst         = 1'b0;
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    tick();
    chk_idle_outputs("post_rst");

    // Single strobe: result for exactly one cycle
    A = tbl[0].a; B = tbl[0].b; C = tbl[0].c; op1 = tbl[0].o1; op2 = tbl[0].o2;
    in_valid = 1'b1;
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_S1", 32'(S1), 32'(tbl[0].e1));
    chk("single_S2", 32'(S2), 32'(tbl[0].e2));
    in_valid = 1'b0;
    tick();
    chk("single_fall", 32'(out_valid), 32'd0);

    // Table vectors back-to-back
    for (int i = 0; i < 5; i++) begin
      A = tbl[i].a; B = tbl[i].b; C = tbl[i].c; op1 = tbl[i].o1; op2 = tbl[i].o2;
      in_valid = 1'b1;
      tick();
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_S1", 32'(S1), 32'(tbl[i].e1));
      chk("tbl_S2", 32'(S2), 32'(tbl[i].e2));
    end
    in_valid = 1'b0;
    A = W'($urandom); op1 = 3'($urandom);
    tick();
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_S1", 32'(S1), 32'(tbl[4].e1));
    chk("hold_S2", 32'(S2), 32'(tbl[4].e2));

    // Randomized direct mode against the model
    exp1 = tbl[4].e1;
    exp2 = tbl[4].e2;
    for (int n = 0; n < 60; n++) begin
      A = W'($urandom); B = W'($urandom); C = W'($urandom);
      op1 = 3'($urandom); op2 = 3'($urandom);
      in_valid = 1'($urandom);
      sweep_start = 1'b0;
      if (in_valid) begin
        exp1 = model(op1, A, B, C);
        exp2 = model(op2, A, B, C);
      end
      tick();
      chk("rand_valid", 32'(out_valid), 32'(in_valid));
      chk("rand_S1", 32'(S1), 32'(exp1));
      chk("rand_S2", 32'(S2), 32'(exp2));
    end
    in_valid = 1'b0;
    tick();

`ifdef COMPUERTAS_SWEEP_EN
    // Plain sweep AND3 / OR3
    op1 = 3'd0; op2 = 3'd1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("start_busy", 32'(sweep_busy), 32'd1);
    chk("start_valid", 32'(out_valid), 32'd0);
    run_sweep(3'd0, 3'd1);

    // Direct strobe and sweep start together
    A = tbl[0].a; B = tbl[0].b; C = tbl[0].c; op1 = 3'd0; op2 = 3'd2;
    in_valid = 1'b1; sweep_start = 1'b1;
    tick();
    in_valid = 1'b0; sweep_start = 1'b0;
    chk("both_valid", 32'(out_valid), 32'd1);
    chk("both_S1", 32'(S1), 32'(tbl[0].e1));
    chk("both_S2", 32'(S2), 32'(tbl[0].e2));
    chk("both_busy", 32'(sweep_busy), 32'd1);
    run_sweep(3'd0, 3'd2);

    // Reset in the middle of a sweep
    op1 = 3'd2; op2 = 3'd7; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (3) tick();
    tick();
    chk("mid_idx", 32'(sweep_idx), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_S1", 32'(S1), 32'd0);
    chk("mid_rst_S2", 32'(S2), 32'd0);
    chk_idle_outputs("mid_rst");
    tick();
    chk_idle_outputs("mid_after");
    op1 = 3'd6; op2 = 3'd5; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("restart_busy", 32'(sweep_busy), 32'd1);
    run_sweep(3'd6, 3'd5);
`else
    // Sweep engine absent: sweep_start has no effect
    in_valid = 1'b0; sweep_start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_idle_outputs("nosweep");
    end
    A = tbl[1].a; B = tbl[1].b; C = tbl[1].c; op1 = tbl[1].o1; op2 = tbl[1].o2;
    in_valid = 1'b1;
    tick();
    chk("nosweep_valid", 32'(out_valid), 32'd1);
    chk("nosweep_S1", 32'(S1), 32'(tbl[1].e1));
    chk("nosweep_S2", 32'(S2), 32'(tbl[1].e2));
    chk("nosweep_busy", 32'(sweep_busy), 32'd0);
    in_valid = 1'b0; sweep_start = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compuertas_sweep.md
# compuertas_sweep

Parametrised, registered successor to the three-input gate block: evaluates two independently selectable three-input logic functions bit-wise over WIDTH-bit operands A, B, C, and drives S1/S2 with one-cycle latency and a valid strobe. It also contains a sweep engine that enumerates all eight ABC combinations and emits the full truth table of both selected functions without external stimulus. It sits between stimulus sources (switches or bench) and display or checker logic in the lab designs.

## Interface
- WIDTH, 4, operand/result lane count (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- A, B, C  in  WIDTH  operands, sampled when in_valid=1
- op1, op2  in  3  function select for S1/S2; sampled with in_valid or sweep_start
- in_valid  in  1  operand strobe
- sweep_start  in  1  start truth-table sweep (honoured only in IDLE)
- S1, S2  out  WIDTH  registered results
- out_valid  out  1  S1/S2/sweep_idx valid this cycle
- sweep_idx  out  3  combination producing current result during sweep ({A,B,C} bit order), else 0
- sweep_busy  out  1  sweep engine active
- sweep_done  out  1  one-cycle pulse coincident with last sweep result

## Operation
- Op encoding, bit-wise per lane: 0 AND3, 1 OR3, 2 XOR3, 3 NAND3, 4 NOR3, 5 XNOR3, 6 MAJ (majority), 7 MUX (C ? B : A). All codes legal.
- Direct mode (IDLE): in_valid=1 at edge t → S1=f(op1), S2=f(op2) and out_valid=1 at t+1. in_valid=0 → out_valid=0; S1/S2 hold last value.
- FSM: IDLE → SWEEP on sweep_start; SWEEP runs idx 0..7, one per cycle; after idx 7 → DRAIN for one cycle → IDLE.
- On entering SWEEP, op1/op2 are latched; idx bits are replicated across all lanes (A=idx[2], B=idx[1], C=idx[0]).
- in_valid is ignored in SWEEP and DRAIN (no output produced). sweep_start is ignored outside IDLE.
- in_valid and sweep_start in the same IDLE cycle: direct result at t+1, sweep results follow from t+2.
- Reset: S1=S2=0, out_valid=0, sweep_idx=0, sweep_busy=0, sweep_done=0, FSM=IDLE, counter=0. Reset mid-sweep aborts with no sweep_done.

## Timing
- Direct latency: 1 cycle, throughput 1 result/cycle, no backpressure.
- sweep_start at edge t: sweep_busy=1 from t+1 through t+9; results idx 0..7 on t+2..t+9 with out_valid=1 and sweep_idx=idx; sweep_done=1 only at t+9; IDLE again at t+10, so the next sweep_start is accepted at t+10.
- sweep_idx returns to 0 when out_valid falls.

## Configuration
- COMPUERTAS_SWEEP_EN defined: sweep FSM, counter and op latch are built as above.
- Not defined: sweep logic is removed; ports are kept; sweep_start is ignored; sweep_busy, sweep_done and sweep_idx are tied to 0; in_valid is always honoured.

## Structure
- Shared package compuertas_pkg: op code localparams (OP_AND3..OP_MUX), FSM state encoding (ST_IDLE, ST_SWEEP, ST_DRAIN), and the 3-bit op width constant.
- Sub-module gate_eval: combinational WIDTH-bit evaluator (op, A, B, C → Y), instantiated twice (S1, S2). Top holds the FSM, the registers and the operand mux.

## Test plan
- rst=1 for 2 cycles with random inputs → every output 0; out_valid remains 0 after release with in_valid=0.
- WIDTH=4, A=1100, B=1010, C=1111, op1=0, op2=2, in_valid pulse → next cycle S1=1000, S2=1001, out_valid=1 for exactly one cycle.
- A=0011, B=0101, C=1111, op1=6, op2=7 → S1=0111, S2=0101 one cycle later; back-to-back in_valid gives results on consecutive cycles.
- op1=0, op2=1, sweep_start → 8 consecutive out_valid with sweep_idx 0..7; S1=0000 except 1111 at idx 7; S2=0000 at idx 0, else 1111; sweep_done only with idx 7; sweep_busy high for 9 cycles.
- During the sweep, toggle in_valid and sweep_start and change op1/op2 → exactly 8 results, unchanged values, no second sweep.
- Assert rst while sweep_idx=3 → next cycle all outputs 0, no sweep_done; a new sweep_start restarts at idx 0.
- Build without COMPUERTAS_SWEEP_EN → sweep_start has no effect, sweep outputs stay 0, direct-mode tests pass unchanged.
